// File: rtl/disp_pixbuf.sv
// disp_pixbuf: AXI read-beat FIFO that unpacks each 64-bit word into two 24-bit RGB pixels
module disp_pixbuf #(
  parameter int DEPTH_LOG2 = 9,
  parameter int BURST_LEN  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARST,
  input  logic [63:0]           RDATA,
  input  logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  FLUSH,
  output logic                  BUF_WREADY,
  input  logic                  PIX_REQ,
  output logic                  PIX_VALID,
  output logic [23:0]           PIX_RGB,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  UNDERRUN,
  output logic                  OVERFLOW
);
  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] BURST = BURST_LEN[DEPTH_LOG2:0];
  logic [63:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic hsel, beat, full, empty, push, rd, pop;
  always_comb begin
    beat  = RVALID & RREADY;
    full  = LEVEL == DEPTH;
    empty = LEVEL == '0;
    push  = beat & ~full & ~FLUSH;
    rd    = PIX_REQ & ~empty & ~FLUSH;
    pop   = rd & hsel;
  end
  assign BUF_WREADY = (DEPTH - LEVEL) >= BURST;
  always_ff @(posedge ACLK)
    if (push) mem[wptr] <= RDATA;
  // pixel data is not cleared by FLUSH; it simply holds until the next request
  always_ff @(posedge ACLK)
    if (ARST) PIX_RGB <= '0;
    else if (PIX_REQ && !FLUSH) PIX_RGB <= empty ? '0 : (hsel ? mem[rptr][55:32] : mem[rptr][23:0]);
  always_ff @(posedge ACLK) begin
    if (ARST || FLUSH) begin
      wptr      <= '0;
      rptr      <= '0;
      hsel      <= 1'b0;
      LEVEL     <= '0;
      UNDERRUN  <= 1'b0;
      OVERFLOW  <= 1'b0;
      PIX_VALID <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (rd) hsel <= ~hsel;
      LEVEL     <= (push && !pop) ? LEVEL + 1'b1 : ((pop && !push) ? LEVEL - 1'b1 : LEVEL);
      PIX_VALID <= rd;
      if (PIX_REQ && empty) UNDERRUN <= 1'b1;
      if (beat && full) OVERFLOW <= 1'b1;
    end
  end
endmodule

// File: tb/tb_disp_pixbuf.sv
// tb_disp_pixbuf: randomized bench against a pixel-queue reference model
module tb_disp_pixbuf;
  logic ACLK = 1'b0;
  logic ARST, RVALID, RREADY, FLUSH, PIX_REQ;
  logic [63:0] RDATA;
  logic BUF_WREADY, PIX_VALID, UNDERRUN, OVERFLOW;
  logic [23:0] PIX_RGB;
  logic [9:0] LEVEL;
  int tests = 0;
  int fails = 0;
  logic [23:0] q[$];
  logic exp_valid, exp_unf, exp_ovf;
  logic [23:0] exp_rgb;

  disp_pixbuf #(.DEPTH_LOG2(9), .BURST_LEN(16)) dut (
    .ACLK(ACLK), .ARST(ARST), .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .FLUSH(FLUSH), .BUF_WREADY(BUF_WREADY), .PIX_REQ(PIX_REQ), .PIX_VALID(PIX_VALID),
    .PIX_RGB(PIX_RGB), .LEVEL(LEVEL), .UNDERRUN(UNDERRUN), .OVERFLOW(OVERFLOW)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mlevel();
    return (q.size() + 1) / 2;
  endfunction

  task automatic check_all();
    check("level", 32'(LEVEL), 32'(mlevel()));
    check("wready", 32'(BUF_WREADY), 32'(512 - mlevel() >= 16));
    check("pix_valid", 32'(PIX_VALID), 32'(exp_valid));
    check("pix_rgb", 32'(PIX_RGB), 32'(exp_rgb));
    check("underrun", 32'(UNDERRUN), 32'(exp_unf));
    check("overflow", 32'(OVERFLOW), 32'(exp_ovf));
  endtask

  task automatic cycle(input logic v, input logic rr, input logic [63:0] d, input logic req, input logic fl);
    int lvl;
    lvl = mlevel();
    RVALID = v; RREADY = rr; RDATA = d; PIX_REQ = req; FLUSH = fl;
    if (fl) begin
      q.delete();
      exp_valid = 1'b0; exp_unf = 1'b0; exp_ovf = 1'b0;
    end else begin
      exp_valid = req && q.size() > 0;
      if (req) exp_rgb = exp_valid ? q.pop_front() : 24'h0;
      if (req && !exp_valid) exp_unf = 1'b1;
      if (v && rr) begin
        if (lvl < 512) begin
          q.push_back(d[23:0]);
          q.push_back(d[55:32]);
        end else exp_ovf = 1'b1;
      end
    end
    @(posedge ACLK);
    #1;
    check_all();
  endtask

  function automatic logic [63:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic push(input logic [63:0] d);
    cycle(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic req();
    cycle(1'b0, 1'($urandom_range(1)), 64'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] k;
    ARST = 1'b1; RVALID = 1'b0; RREADY = 1'b0; FLUSH = 1'b0; PIX_REQ = 1'b0; RDATA = '0;
    repeat (3) @(posedge ACLK);
    #1;
    exp_valid = 1'b0; exp_unf = 1'b0; exp_ovf = 1'b0; exp_rgb = 24'h0;
    check_all();
    ARST = 1'b0;
    for (int i = 0; i < 16; i++) begin
      k = 8'(i);
      push({8'h00, {3{k + 8'd1}}, 8'h00, {3{k}}});
    end
    check("burst_level", 32'(LEVEL), 32'd16);
    for (int i = 0; i < 32; i++) req();
    req();
    check("underrun_rgb", 32'(PIX_RGB), 32'h0);
    push(rnd_word());
    req();
    repeat (2) req();
    for (int i = 0; i < 497; i++) push(rnd_word());
    check("thresh_wready", 32'(BUF_WREADY), 32'd0);
    repeat (2) req();
    check("thresh_restore", 32'(BUF_WREADY), 32'd1);
    for (int i = 0; i < 20; i++) push(rnd_word());
    check("full_level", 32'(LEVEL), 32'd512);
    check("full_ovf", 32'(OVERFLOW), 32'd1);
    while (q.size() > 0) req();
    for (int i = 0; i < 8; i++) push(rnd_word());
    for (int i = 0; i < 200; i++) cycle(i % 2 == 0, 1'b1, rnd_word(), 1'b1, 1'b0);
    while (q.size() > 0) req();
    for (int i = 0; i < 20; i++) push(rnd_word());
    req();
    cycle(1'b1, 1'b1, rnd_word(), 1'b1, 1'b1);
    check("flush_level", 32'(LEVEL), 32'd0);
    push(rnd_word());
    req();
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0), rnd_word(),
            1'($urandom_range(1)), 1'($urandom_range(199) == 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
